// File: rtl/rr_onehot_arbiter.sv
// Edge-capturing request arbiter that feeds a one-hot grant into a 16-to-4 encoder.
// Define RR_ARB_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module rr_onehot_arbiter #(
  parameter int N     = 16,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         grant_ack,
  input  logic         clr_ovf,
  output logic [N-1:0] grant,
  output logic         grant_en,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [N-1:0]       req_d;
  logic [N-1:0]       rise;
  logic [N-1:0]       clr_mask;
  logic [N-1:0]       pending_nx;
  logic [N-1:0]       grant_nx;
  logic               grant_en_nx;
  logic               overflow_nx;
  logic [PTR_W-1:0]   sel;

`ifdef RR_ARB_EN
  logic [PTR_W-1:0]   ptr, ptr_nx;
  logic [PTR_W-1:0]   grant_idx, grant_idx_nx;

  // First set bit at or above start, wrapping past N-1 back to 0.
  function automatic logic [PTR_W-1:0] pick(input logic [N-1:0] vec,
                                            input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] idx;
    logic             found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start + PTR_W'(i);
      if (!found && vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction
`else
  // Lowest set bit wins; scanning downward lets the lowest hit overwrite.
  function automatic logic [PTR_W-1:0] pick(input logic [N-1:0] vec);
    pick = {PTR_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pick = PTR_W'(i);
      end
    end
  endfunction
`endif

  // Next-state, grant, pending and overflow computation.
  always_comb begin
    rise        = req_in & ~req_d;
    clr_mask    = {N{1'b0}};
    state_nx    = state;
    grant_nx    = grant;
    grant_en_nx = grant_en;
`ifdef RR_ARB_EN
    sel          = pick(pending, ptr);
    ptr_nx       = ptr;
    grant_idx_nx = grant_idx;
`else
    sel          = pick(pending);
`endif
    case (state)
      IDLE: begin
        if (pending != {N{1'b0}}) begin
          grant_nx    = {{(N-1){1'b0}}, 1'b1} << sel;
          grant_en_nx = 1'b1;
          state_nx    = GRANT;
`ifdef RR_ARB_EN
          grant_idx_nx = sel;
`endif
        end else begin
          grant_nx    = {N{1'b0}};
          grant_en_nx = 1'b0;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          clr_mask    = grant;
          grant_nx    = {N{1'b0}};
          grant_en_nx = 1'b0;
          state_nx    = IDLE;
`ifdef RR_ARB_EN
          ptr_nx      = grant_idx + {{(PTR_W-1){1'b0}}, 1'b1};
`endif
        end else begin
          state_nx = GRANT;
        end
      end
      default: begin
        grant_nx    = {N{1'b0}};
        grant_en_nx = 1'b0;
        state_nx    = IDLE;
      end
    endcase
    // A rise landing on the bit being acked re-arms it without counting as overflow.
    pending_nx = (pending & ~clr_mask) | rise;
    if ((rise & pending & ~clr_mask) != {N{1'b0}}) begin
      overflow_nx = 1'b1;
    end else if (clr_ovf) begin
      overflow_nx = 1'b0;
    end else begin
      overflow_nx = overflow;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_d    <= {N{1'b0}};
      pending  <= {N{1'b0}};
      grant    <= {N{1'b0}};
      grant_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      req_d    <= req_in;
      pending  <= pending_nx;
      grant    <= grant_nx;
      grant_en <= grant_en_nx;
      overflow <= overflow_nx;
    end
  end

`ifdef RR_ARB_EN
  // Round-robin pointer and index of the grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= {PTR_W{1'b0}};
      grant_idx <= {PTR_W{1'b0}};
    end else begin
      ptr       <= ptr_nx;
      grant_idx <= grant_idx_nx;
    end
  end
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter; expectations follow RR_ARB_EN when defined.
module tb_rr_onehot_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_in;
  logic        grant_ack;
  logic        clr_ovf;
  logic [15:0] grant;
  logic        grant_en;
  logic [15:0] pending;
  logic        overflow;

  int passed = 0;
  int checks = 0;

  rr_onehot_arbiter #(.N(16), .PTR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .grant_ack(grant_ack),
    .clr_ovf(clr_ovf), .grant(grant), .grant_en(grant_en),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Downstream 16-to-4 encoder model.
  function automatic logic [3:0] enc16(input logic [15:0] v);
    enc16 = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) enc16 = 4'(i);
  endfunction

  // From IDLE with something pending: grant appears, then ack retires it.
  task automatic grant_cycle(input string tag, input logic [15:0] exp);
    step();
    check({tag, "_grant"}, {16'h0, grant}, {16'h0, exp});
    check({tag, "_en"}, {31'h0, grant_en}, 32'd1);
    grant_ack = 1'b1;
    step();
    check({tag, "_ack_en"}, {31'h0, grant_en}, 32'd0);
    check({tag, "_ack_grant"}, {16'h0, grant}, 32'd0);
    grant_ack = 1'b0;
  endtask

  logic [15:0] order2 [2];
  logic [15:0] order4 [4];

  initial begin
`ifdef RR_ARB_EN
    order2 = '{16'h8000, 16'h0001};
    order4 = '{16'h2000, 16'h4000, 16'h8000, 16'h0002};
`else
    order2 = '{16'h0001, 16'h8000};
    order4 = '{16'h0002, 16'h2000, 16'h4000, 16'h8000};
`endif
    rst_n = 1'b0; req_in = 16'h0; grant_ack = 1'b0; clr_ovf = 1'b0;
    #12;
    check("rst_grant", {16'h0, grant}, 32'd0);
    check("rst_en", {31'h0, grant_en}, 32'd0);
    check("rst_pending", {16'h0, pending}, 32'd0);
    check("rst_ovf", {31'h0, overflow}, 32'd0);
    step();
    rst_n = 1'b1;

    // Single request, two-clock latency, encoder sees index 3.
    req_in = 16'h0008;
    step();
    check("t1_pending", {16'h0, pending}, 32'h0008);
    check("t1_en_early", {31'h0, grant_en}, 32'd0);
    req_in = 16'h0000;
    step();
    check("t1_grant", {16'h0, grant}, 32'h0008);
    check("t1_en", {31'h0, grant_en}, 32'd1);
    check("t1_enc", {28'h0, enc16(grant)}, 32'd3);
    grant_ack = 1'b1;
    step();
    check("t1_ack_en", {31'h0, grant_en}, 32'd0);
    check("t1_ack_pending", {16'h0, pending}, 32'd0);
    grant_ack = 1'b0;

    // Two simultaneous requests.
    req_in = 16'h8001;
    step();
    check("t2_pending", {16'h0, pending}, 32'h8001);
    req_in = 16'h0000;
    grant_cycle("t2_a", order2[0]);
    grant_cycle("t2_b", order2[1]);
    check("t2_pending_end", {16'h0, pending}, 32'd0);

    // Requests arriving while bit 12 is held granted.
    req_in = 16'h1000;
    step();
    step();
    check("t3_grant12", {16'h0, grant}, 32'h1000);
    req_in = 16'hF000;
    step();
    req_in = 16'hF002;
    step();
    check("t3_pending", {16'h0, pending}, 32'hF002);
    check("t3_hold", {16'h0, grant}, 32'h1000);
    grant_ack = 1'b1;
    step();
    check("t3_pending_ack", {16'h0, pending}, 32'hE002);
    grant_ack = 1'b0;
    req_in = 16'h0000;
    for (int i = 0; i < 4; i++) grant_cycle($sformatf("t3_g%0d", i), order4[i]);
    check("t3_pending_end", {16'h0, pending}, 32'd0);

    // Hold without ack while other lines rise.
    req_in = 16'h0100;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      req_in = 16'h0100 | (16'h0001 << i);
      step();
      check($sformatf("t4_hold%0d", i), {15'h0, grant_en, grant}, {15'h0, 1'b1, 16'h0100});
    end
    check("t4_pending", {16'h0, pending}, 32'h03FF);
    check("t4_ovf", {31'h0, overflow}, 32'd0);
    req_in = 16'h0000;
    grant_ack = 1'b1;
    for (int i = 0; i < 60 && pending != 16'h0; i++) step();
    grant_ack = 1'b0;
    step();
    check("t4_drain_pending", {16'h0, pending}, 32'd0);
    check("t4_drain_en", {31'h0, grant_en}, 32'd0);

    // Overflow, clear, and same-cycle set/clear on bit 3.
    req_in = 16'h0008;
    step();
    req_in = 16'h0000;
    step();
    check("t5_grant", {16'h0, grant}, 32'h0008);
    req_in = 16'h0008;
    step();
    check("t5_ovf_set", {31'h0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    step();
    check("t5_ovf_clr", {31'h0, overflow}, 32'd0);
    clr_ovf = 1'b0;
    req_in = 16'h0000;
    step();
    req_in = 16'h0008;
    grant_ack = 1'b1;
    step();
    check("t5_sc_pending", {16'h0, pending}, 32'h0008);
    check("t5_sc_ovf", {31'h0, overflow}, 32'd0);
    check("t5_sc_en", {31'h0, grant_en}, 32'd0);
    grant_ack = 1'b0;
    grant_cycle("t5_regrant", 16'h0008);
    check("t5_pending_end", {16'h0, pending}, 32'd0);
    req_in = 16'h0000;

    // Asynchronous reset mid-grant, request held through release.
    req_in = 16'h00F0;
    step();
    step();
    check("t6_en", {31'h0, grant_en}, 32'd1);
    check("t6_pending", {16'h0, pending}, 32'h00F0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {grant_en, overflow, grant, pending}, 34'h0);
    req_in = 16'h0001;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_rel_pending", {16'h0, pending}, 32'h0001);
    check("t6_rel_en_early", {31'h0, grant_en}, 32'd0);
    step();
    check("t6_rel_grant", {16'h0, grant}, 32'h0001);
    check("t6_rel_en", {31'h0, grant_en}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
